router_pkt_fifo: RTL and testbench

Parametrised packet-aware FIFO for the router datapath. It is the next generation of the single-width router FIFO, with configurable data width, depth and length-field position. Each stored word carries a start-of-packet tag. The read side tracks packet boundaries from the header length field and produces registered `sop_out`/`eop_out` markers, an occupancy level, an almost-full warning and a sticky framing-error flag. It sits between the router input FSM (write side) and each output port's read logic, one instance per output channel.

---
 rtl/router_pkt_fifo.sv | 147 ++++++++++++++
 tb/tb_router_pkt_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router output channel: stores {sop, data} words and
// tracks packet boundaries on the read side from the header length field.
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int LEN_LSB  = 2,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     soft_rst,
    input  logic                     wr_en,
    input  logic                     sop_in,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_vld,
    output logic                     sop_out,
    output logic                     eop_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frm_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = DATA_W - LEN_LSB;
    localparam int RW = LW + 1;

    typedef logic [AW:0]     ptr_t;
    typedef logic [RW-1:0]   rem_t;
    typedef logic [DATA_W:0] word_t;

    word_t             mem_q [DEPTH];

    ptr_t              wr_ptr_q,   wr_ptr_d;
    ptr_t              rd_ptr_q,   rd_ptr_d;
    logic [AW:0]       level_q,    level_d;
    rem_t              rem_q,      rem_d;
    logic              frm_err_q,  frm_err_d;
    logic [DATA_W-1:0] dout_q,     dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              sop_out_q,  sop_out_d;
    logic              eop_out_q,  eop_out_d;

    logic              clear;
    logic              wr_acc;
    logic              rd_acc;
    word_t             rd_word;
    logic              rd_tag;
    logic [LW-1:0]     rd_len;

    // Hard reset and channel-timeout flush act identically and win over any access.
    assign clear   = !rst || soft_rst;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign almost_full = (level_q >= (AW+1)'(AFULL_TH));

    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;

    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_tag  = rd_word[DATA_W];
    assign rd_len  = rd_word[DATA_W-1:LEN_LSB];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rem_d      = rem_q;
        frm_err_d  = frm_err_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        sop_out_d  = 1'b0;
        eop_out_d  = 1'b0;

        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            rem_d     = '0;
            frm_err_d = 1'b0;
            dout_d    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end

            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + ptr_t'(1);
                dout_d     = rd_word[DATA_W-1:0];
                dout_vld_d = 1'b1;
                if (rd_tag) begin
                    // Header arriving while payload is still owed means the previous packet was cut short.
                    sop_out_d = 1'b1;
                    rem_d     = rem_t'(rd_len) + rem_t'(1);
                    if (rem_q != '0) begin
                        frm_err_d = 1'b1;
                    end
                end else if (rem_q != '0) begin
                    rem_d     = rem_q - rem_t'(1);
                    eop_out_d = (rem_q == rem_t'(1));
                end else begin
                    frm_err_d = 1'b1;
                end
            end

            unique case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        level_q    <= level_d;
        rem_q      <= rem_d;
        frm_err_q  <= frm_err_d;
        dout_q     <= dout_d;
        dout_vld_q <= dout_vld_d;
        sop_out_q  <= sop_out_d;
        eop_out_q  <= eop_out_d;
    end

    // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc && !clear) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {sop_in, din};
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign sop_out  = sop_out_q;
    assign eop_out  = eop_out_q;
    assign level    = level_q;
    assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo at DATA_W=8, DEPTH=16, LEN_LSB=2.
module tb_router_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst;
    logic       wr_en;
    logic       sop_in;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       dout_vld;
    logic       sop_out;
    logic       eop_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] level;
    logic       frm_err;

    router_pkt_fifo #(
        .DATA_W  (8),
        .DEPTH   (16),
        .LEN_LSB (2),
        .AFULL_TH(14)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (soft_rst),
        .wr_en      (wr_en),
        .sop_in     (sop_in),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .sop_out    (sop_out),
        .eop_out    (eop_out),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .level      (level),
        .frm_err    (frm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       sop;
        logic [7:0] din;
        logic       rd;
        logic       srst;
        logic       vld;
        logic [7:0] dout;
        logic       sop_o;
        logic       eop_o;
        logic [4:0] lvl;
        logic       frm;
        logic       emp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic s, input logic [7:0] d,
                         input logic r, input logic sr);
        wr_en    = w;
        sop_in   = s;
        din      = d;
        rd_en    = r;
        soft_rst = sr;
    endtask

    function automatic vec_t mk(input logic w, input logic s, input logic [7:0] d,
                                input logic r, input logic sr, input logic v,
                                input logic [7:0] q, input logic so, input logic eo,
                                input logic [4:0] l, input logic f, input logic e);
        vec_t t;
        t.wr = w;  t.sop = s;    t.din = d;    t.rd = r;  t.srst = sr;
        t.vld = v; t.dout = q;   t.sop_o = so; t.eop_o = eo;
        t.lvl = l; t.frm = f;    t.emp = e;
        return t;
    endfunction

    initial begin
        // Single packet: header 0x0C (L=3), three payload words, parity 0x5E.
        vecs[0]  = mk(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 8'hA3, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 8'h5E, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h0C, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'hA1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'hA2, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'hA3, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h5E, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h5E, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        // Truncated packet: header L=2 with one payload word, then a fresh L=0 packet.
        vecs[11] = mk(1'b1, 1'b1, 8'h08, 1'b0, 1'b0,  1'b0, 8'h5E, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 8'h11, 1'b0, 1'b0,  1'b0, 8'h5E, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b0,  1'b0, 8'h5E, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 8'h22, 1'b0, 1'b0,  1'b0, 8'h5E, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h08, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h11, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h22, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h22, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        // Flush, then an orphan (untagged) first word.
        vecs[20] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        vecs[21] = mk(1'b1, 1'b0, 8'h33, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
        vecs[22] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h33, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        vecs[23] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        check("rst empty",    32'(empty),       32'd1);
        check("rst full",     32'(full),        32'd0);
        check("rst afull",    32'(almost_full), 32'd0);
        check("rst level",    32'(level),       32'd0);
        check("rst dout",     32'(dout),        32'd0);
        check("rst dout_vld", 32'(dout_vld),    32'd0);
        check("rst frm_err",  32'(frm_err),     32'd0);
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].wr, vecs[i].sop, vecs[i].din, vecs[i].rd, vecs[i].srst);
            step();
            check($sformatf("v%0d dout_vld", i), 32'(dout_vld), 32'(vecs[i].vld));
            check($sformatf("v%0d dout", i),     32'(dout),     32'(vecs[i].dout));
            if (vecs[i].vld) begin
                check($sformatf("v%0d sop_out", i), 32'(sop_out), 32'(vecs[i].sop_o));
                check($sformatf("v%0d eop_out", i), 32'(eop_out), 32'(vecs[i].eop_o));
            end
            check($sformatf("v%0d level", i),   32'(level),   32'(vecs[i].lvl));
            check($sformatf("v%0d frm_err", i), 32'(frm_err), 32'(vecs[i].frm));
            check($sformatf("v%0d empty", i),   32'(empty),   32'(vecs[i].emp));
        end

        // Hard reset drops a write issued in the same cycle.
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'hAB, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst prio level", 32'(level), 32'd0);
        check("rst prio empty", 32'(empty), 32'd1);

        // Fill to full, watching almost_full from level 14.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
            step();
            check($sformatf("fill%0d level", i), 32'(level),       32'(i + 1));
            check($sformatf("fill%0d afull", i), 32'(almost_full), 32'((i + 1) >= 14));
            check($sformatf("fill%0d full", i),  32'(full),        32'(i == 15));
        end
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        step();
        check("over level", 32'(level), 32'd16);
        check("over full",  32'(full),  32'd1);
        drive(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        step();
        check("full rw dout",  32'(dout),     32'h40);
        check("full rw vld",   32'(dout_vld), 32'd1);
        check("full rw level", 32'(level),    32'd15);
        check("full rw full",  32'(full),     32'd0);
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            step();
            check($sformatf("drain%0d dout", i), 32'(dout), 32'(8'h40 + i));
        end
        check("drain empty", 32'(empty), 32'd1);
        check("drain level", 32'(level), 32'd0);

        // Refill across the pointer wrap and drain again.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
            step();
        end
        check("refill full",  32'(full),  32'd1);
        check("refill level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            step();
            check($sformatf("wrap%0d dout", i), 32'(dout), 32'(8'h60 + i));
        end
        check("wrap empty", 32'(empty), 32'd1);
        check("wrap level", 32'(level), 32'd0);
        check("wrap full",  32'(full),  32'd0);

        // Empty with read and write together: only the write lands.
        drive(1'b1, 1'b0, 8'h80, 1'b1, 1'b0);
        step();
        check("empty rw vld",   32'(dout_vld), 32'd0);
        check("empty rw level", 32'(level),    32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'(8'h81 + i), 1'b1, 1'b0);
            step();
            check($sformatf("sim%0d vld", i),   32'(dout_vld), 32'd1);
            check($sformatf("sim%0d dout", i),  32'(dout),     32'(8'h80 + i));
            check($sformatf("sim%0d level", i), 32'(level),    32'd1);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check("sim last dout",  32'(dout),  32'h8A);
        check("sim last level", 32'(level), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("hold dout", 32'(dout),     32'h8A);
        check("hold vld",  32'(dout_vld), 32'd0);

        // Soft reset with level 7 and both requests asserted.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
            step();
        end
        check("pre srst level", 32'(level), 32'd7);
        drive(1'b1, 1'b1, 8'h0C, 1'b1, 1'b1);
        step();
        check("srst level", 32'(level),    32'd0);
        check("srst empty", 32'(empty),    32'd1);
        check("srst dout",  32'(dout),     32'd0);
        check("srst vld",   32'(dout_vld), 32'd0);
        check("srst frm",   32'(frm_err),  32'd0);
        drive(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        step();
        check("post level", 32'(level), 32'd3);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check("post hdr dout", 32'(dout),    32'h04);
        check("post hdr sop",  32'(sop_out), 32'd1);
        check("post hdr eop",  32'(eop_out), 32'd0);
        step();
        check("post pl dout", 32'(dout),    32'h99);
        check("post pl sop",  32'(sop_out), 32'd0);
        check("post pl eop",  32'(eop_out), 32'd0);
        step();
        check("post par dout", 32'(dout),    32'h77);
        check("post par eop",  32'(eop_out), 32'd1);
        check("post frm",      32'(frm_err), 32'd0);
        check("post empty",    32'(empty),   32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
